// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit BCD up/down counter stepped by an internal
// clock-enable tick derived from clkin, with per-digit 7-segment decode.
module bcd_tick_counter #(
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1,
  parameter int DIGITS         = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   ld_val,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0]       div_cnt;
  logic                div_last;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] ld_clean;
  logic                step_wrap;
  logic                carry;
  logic [3:0]          digit;

  assign div_last = (div_cnt == DIV_LAST);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Free-running divider 0..DIV-1; only clr (or reset) pulls it back early.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr || div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Registered tick: high in the cycle after the divider reached its last value.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= div_last && !clr;
    end
  end

  // Next-step value via a digit-wise carry/borrow ripple, plus sanitised load value.
  always_comb begin
    step_val = count;
    ld_clean = '0;
    carry    = 1'b1;
    digit    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      ld_clean[4*i +: 4] = (ld_val[4*i +: 4] > 4'd9) ? 4'd0 : ld_val[4*i +: 4];
    end
    // A carry/borrow surviving past the top digit means all-9s -> 0 or all-0s -> 9.
    step_wrap = carry;
  end

  // Count register with clr > load > enabled tick step priority; wrap is a one-cycle pulse.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= ld_clean;
      wrap  <= 1'b0;
    end else if (tick && en) begin
      count <= step_val;
      wrap  <= step_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Combinational per-digit segment decode with optional inversion.
  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (SEG_ACTIVE_LOW != 0) begin
        seg[7*i +: 7] = ~seg7(count[4*i +: 4]);
      end else begin
        seg[7*i +: 7] = seg7(count[4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter with DIV=5, DIGITS=2; a second instance
// shares all inputs and exercises active-low segment outputs.
module tb_bcd_tick_counter;

  logic        clkin;
  logic        rst, en, up, clr, load;
  logic [7:0]  ld_val;
  logic        tick, wrap, tick_n, wrap_n;
  logic [7:0]  count, count_n;
  logic [13:0] seg, seg_n;

  int checks;
  int failures;
  int cyc;
  int last_cyc;
  int t0;
  logic [8:0] exp_q[$];
  logic [6:0] segtab [10];

  localparam logic [13:0] SEG_ZERO = {7'h7E, 7'h7E};

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(2), .DIGITS(2), .SEG_ACTIVE_LOW(0)) dut (
    .clkin(clkin), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .ld_val(ld_val), .tick(tick), .count(count), .seg(seg), .wrap(wrap)
  );

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(2), .DIGITS(2), .SEG_ACTIVE_LOW(1)) dut_n (
    .clkin(clkin), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .ld_val(ld_val), .tick(tick_n), .count(count_n), .seg(seg_n), .wrap(wrap_n)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Waits (from a negedge) until tick is seen high at a negedge.
  task automatic wait_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clkin);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load   = 1'b1;
    ld_val = v;
    @(negedge clkin);
    load   = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; ld_val = '0;
    repeat (3) @(negedge clkin);
    checks++;
    if (count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || tick_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_state count=%h tick=%b wrap=%b tick_n=%b required 00/0/0/0", count, tick, wrap, tick_n);
    end
    checks++;
    if (seg !== SEG_ZERO || seg_n !== ~SEG_ZERO) begin
      failures++;
      $display("FAIL reset_seg seg=%h seg_n=%h required %h/%h", seg, seg_n, SEG_ZERO, ~SEG_ZERO);
    end
    rst = 1'b0;
    t0 = cyc;
    wait_tick(20, ok);
    checks++;
    if (!ok || (cyc - t0) != 5) begin
      failures++;
      $display("FAIL first_tick ok=%b cycles=%0d required 5", ok, cyc - t0);
    end
    last_cyc = cyc;
  endtask

  task automatic test_count_up();
    bit ok;
    logic [8:0] e;
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back({1'b0, to_bcd(k)});
      wait_tick(20, ok);
      checks++;
      if (!ok || (k > 1 && (cyc - last_cyc) != 5)) begin
        failures++;
        $display("FAIL tick_period k=%0d ok=%b period=%0d required 5", k, ok, cyc - last_cyc);
      end
      last_cyc = cyc;
      @(negedge clkin);
      e = exp_q.pop_front();
      checks++;
      if ({wrap, count} !== e) begin
        failures++;
        $display("FAIL count_up k=%0d wrap,count=%b,%h required %b,%h", k, wrap, count, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [8:0] e;
    do_load(8'h99);
    checks++;
    if (count !== 8'h99 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_99 count=%h wrap=%b required 99/0", count, wrap);
    end
    exp_q.push_back({1'b1, 8'h00});
    wait_tick(20, ok);
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {wrap, count} !== e) begin
      failures++;
      $display("FAIL wrap_up ok=%b wrap,count=%b,%h required %b,%h", ok, wrap, count, e[8], e[7:0]);
    end
    @(negedge clkin);
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_one_cycle wrap=%b required 0", wrap);
    end
    up = 1'b0;
    exp_q.push_back({1'b1, 8'h99});
    wait_tick(20, ok);
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {wrap, count} !== e) begin
      failures++;
      $display("FAIL wrap_down ok=%b wrap,count=%b,%h required %b,%h", ok, wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_load_sanitize();
    bit ok;
    logic [8:0] e;
    up = 1'b1;
    do_load(8'h0F);
    checks++;
    if (count !== 8'h00 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_0F count=%h wrap=%b required 00/0", count, wrap);
    end
    do_load(8'h19);
    checks++;
    if (count !== 8'h19) begin
      failures++;
      $display("FAIL load_19 count=%h required 19", count);
    end
    exp_q.push_back({1'b0, 8'h20});
    wait_tick(20, ok);
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {wrap, count} !== e) begin
      failures++;
      $display("FAIL carry_19 ok=%b wrap,count=%b,%h required %b,%h", ok, wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_clr_load_tick();
    bit ok;
    logic [8:0] e;
    wait_tick(20, ok);
    clr = 1'b1; load = 1'b1; ld_val = 8'h55;
    @(negedge clkin);
    clr = 1'b0; load = 1'b0;
    checks++;
    if (!ok || count !== 8'h00 || wrap !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL clr_load ok=%b count=%h wrap=%b tick=%b required 00/0/0", ok, count, wrap, tick);
    end
    t0 = cyc;
    exp_q.push_back({1'b0, 8'h01});
    wait_tick(20, ok);
    checks++;
    if (!ok || (cyc - t0) != 5) begin
      failures++;
      $display("FAIL clr_next_tick ok=%b cycles=%0d required 5", ok, cyc - t0);
    end
    last_cyc = cyc;
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if ({wrap, count} !== e) begin
      failures++;
      $display("FAIL after_clr wrap,count=%b,%h required %b,%h", wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_enable_hold();
    bit ok;
    logic [8:0] e;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, ok);
      checks++;
      if (!ok || (cyc - last_cyc) != 5) begin
        failures++;
        $display("FAIL hold_tick k=%0d ok=%b period=%0d required 5", k, ok, cyc - last_cyc);
      end
      last_cyc = cyc;
      @(negedge clkin);
      checks++;
      if (count !== 8'h01 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold_count k=%0d count=%h wrap=%b required 01/0", k, count, wrap);
      end
    end
    en = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    wait_tick(20, ok);
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {wrap, count} !== e) begin
      failures++;
      $display("FAIL resume ok=%b wrap,count=%b,%h required %b,%h", ok, wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_borrow();
    bit ok;
    logic [8:0] e;
    up = 1'b0;
    do_load(8'h10);
    exp_q.push_back({1'b0, 8'h09});
    wait_tick(20, ok);
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {wrap, count} !== e) begin
      failures++;
      $display("FAIL borrow_10 ok=%b wrap,count=%b,%h required %b,%h", ok, wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [8:0] e;
    wait_tick(20, ok);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!ok || count !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || seg !== SEG_ZERO) begin
      failures++;
      $display("FAIL async_rst ok=%b count=%h tick=%b wrap=%b seg=%h required 00/0/0/%h",
               ok, count, tick, wrap, seg, SEG_ZERO);
    end
    @(negedge clkin);
    rst = 1'b0;
    t0 = cyc;
    wait_tick(20, ok);
    checks++;
    if (!ok || (cyc - t0) != 5 || count !== 8'h00) begin
      failures++;
      $display("FAIL post_rst ok=%b cycles=%0d count=%h required 5/00", ok, cyc - t0, count);
    end
    exp_q.push_back({1'b1, 8'h99});
    @(negedge clkin);
    e = exp_q.pop_front();
    checks++;
    if ({wrap, count} !== e) begin
      failures++;
      $display("FAIL post_rst_step wrap,count=%b,%h required %b,%h", wrap, count, e[8], e[7:0]);
    end
  endtask

  task automatic test_seg();
    logic [13:0] s;
    logic [3:0]  d4;
    en = 1'b0;
    for (int d = 0; d < 10; d++) begin
      d4 = 4'(d);
      do_load({d4, d4});
      s = {segtab[d], segtab[d]};
      checks++;
      if (seg !== s || seg_n !== ~s) begin
        failures++;
        $display("FAIL seg_digit d=%0d seg=%h seg_n=%h required %h/%h", d, seg, seg_n, s, ~s);
      end
    end
    do_load(8'h37);
    s = {segtab[3], segtab[7]};
    checks++;
    if (seg !== s) begin
      failures++;
      $display("FAIL seg_mixed seg=%h required %h", seg, s);
    end
    do_load(8'h88);
    checks++;
    if (count_n !== 8'h88 || seg_n !== 14'h0000) begin
      failures++;
      $display("FAIL seg_active_low count_n=%h seg_n=%h required 88/0000", count_n, seg_n);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_cyc = 0;
    segtab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; ld_val = '0;
    @(negedge clkin);
    test_reset();
    test_count_up();
    test_wrap();
    test_load_sanitize();
    test_clr_load_tick();
    test_enable_hold();
    test_borrow();
    test_async_reset();
    test_seg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2.
REQ-003 Parameter DIGITS, default 4, number of BCD digits, range 1..8.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0; 1 inverts all segment outputs.
REQ-005 clkin  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  count enable; gates counting only, not the divider.
REQ-008 up  input  1  direction: 1 = up, 0 = down.
REQ-009 clr  input  1  synchronous clear of count and divider.
REQ-010 load  input  1  synchronous load of ld_val into count.
REQ-011 ld_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
REQ-012 tick  output  1  one-cycle pulse at TICK_HZ.
REQ-013 count  output  4*DIGITS  registered BCD count; digit 0 in bits [3:0].
REQ-014 seg  output  7*DIGITS  per-digit segments {a,b,c,d,e,f,g}, a = MSB of each 7-bit field, digit 0 in bits [6:0].
REQ-015 wrap  output  1  registered one-cycle pulse on full-range wrap.

Function
REQ-016 The divider counter SHALL be $clog2(DIV) bits, count 0..DIV-1, and return to 0 after DIV-1.
REQ-017 tick SHALL be registered and high for exactly one cycle, in the cycle after the divider holds DIV-1; period exactly DIV cycles.
REQ-018 No derived clock SHALL be generated; tick is used only as a clock enable.
REQ-019 Per-edge priority: clr, then load, then (tick AND en) count step, else hold.
REQ-020 clr SHALL zero count and the divider, suppress that cycle's tick and step, and force wrap low.
REQ-021 load SHALL write ld_val into count; any digit > 9 is written as 0; load does not reset the divider and produces no wrap.
REQ-022 Up step: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
REQ-023 Down step: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
REQ-024 Up from all-9s SHALL yield all-0s; down from all-0s SHALL yield all-9s; either case asserts wrap in the cycle after the step.
REQ-025 wrap SHALL otherwise be 0 and never remain high for two consecutive cycles.
REQ-026 Changes to up or en take effect at the next tick; only the value sampled on the tick edge matters.
REQ-027 seg SHALL be a combinational decode of count: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B (hex, active-high); inverted when SEG_ACTIVE_LOW=1.
REQ-028 count SHALL never hold a non-BCD digit.

Reset
REQ-029 rst high SHALL immediately set divider=0, count=0, tick=0, wrap=0, independent of clkin.
REQ-030 While rst is high, seg SHALL show "0" on every digit; the first tick after release comes DIV cycles after the first rising edge with rst low.
REQ-031 rst asserted mid-step or mid-tick SHALL discard the step with no partial carry.

Verification (CLK_HZ=10, TICK_HZ=2, so DIV=5; DIGITS=2)
REQ-032 rst pulse, then en=1, up=1 for 50 cycles -> tick every 5 cycles; count 00,01,...,10; seg[6:0]=7E at reset.
REQ-033 load ld_val=8'h99, then up tick -> count=00 and wrap high for one cycle; down tick from 00 -> count=99 and wrap pulse.
REQ-034 load ld_val=8'h0F -> count=00; load 8'h19 and then up tick -> count=20, no wrap.
REQ-035 clr and load asserted together with tick -> count=00, no step, next tick 5 cycles later.
REQ-036 en=0 across 3 ticks -> count holds and tick continues; async rst mid-cycle -> outputs zero before the next clkin edge.
REQ-037 SEG_ACTIVE_LOW=1 with count=88 -> seg=14'h0000.
